// File: rtl/adpcm_div_pkg.sv
// Shared constants for the ADPCM sequential signed/unsigned divider:
// state encoding, default operand widths and the counter-width helper.
package adpcm_div_pkg;

   // Default operand widths of the 45s / 13ns / 32 divider instance.
   localparam int DIN0_W = 45;
   localparam int DIN1_W = 13;
   localparam int DOUT_W = 32;

   // FSM state encoding, kept as plain 2-bit constants for legacy tools.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   // Width of the iteration counter: ceil(log2(n)), minimum 1.
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/adpcm_div_step.sv
// One combinational restoring-division step: shift the next dividend bit
// into the partial remainder and subtract the divisor when it fits.
module adpcm_div_step
   import adpcm_div_pkg::*;
#(
   parameter int din1_WIDTH = DIN1_W
) (
   input  logic [din1_WIDTH:0]   pr_i,
   input  logic                  bit_i,
   input  logic [din1_WIDTH-1:0] divisor_i,
   output logic [din1_WIDTH:0]   pr_o,
   output logic                  qbit_o
);

   logic [din1_WIDTH:0] shifted;
   logic                unused_pr_msb;

   // The incoming remainder is always below the divisor, so its MSB is
   // zero and dropping it in the shift loses nothing.
   assign unused_pr_msb = pr_i[din1_WIDTH];

   // Shift, compare and conditionally subtract.
   always_comb begin
      shifted = {pr_i[din1_WIDTH-1:0], bit_i};
      qbit_o  = (shifted >= {1'b0, divisor_i});
      pr_o    = qbit_o ? (shifted - {1'b0, divisor_i}) : shifted;
   end

endmodule

// File: rtl/adpcm_main_sdiv_45s_13ns_32_seq.sv
// Iterative radix-2 restoring divider: signed dividend / unsigned divisor,
// truncating toward zero, one quotient bit per clock-enabled cycle.
module adpcm_main_sdiv_45s_13ns_32_seq
   import adpcm_div_pkg::*;
#(
   parameter int ID         = 1,
   parameter int din0_WIDTH = DIN0_W,
   parameter int din1_WIDTH = DIN1_W,
   parameter int dout_WIDTH = DOUT_W
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         ce,
   input  logic                         start,
   input  logic signed [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0]        din1,
   output logic                         busy,
   output logic                         done,
   output logic [dout_WIDTH-1:0]        quot,
   output logic [dout_WIDTH-1:0]        rem,
   output logic                         div_by_zero,
   output logic                         ovf
);

   localparam int               CNT_W    = cnt_width(din0_WIDTH);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(din0_WIDTH - 1);

   // Control and datapath state.
   logic [1:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [din0_WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, shifted out MSB first
   logic [din1_WIDTH-1:0] dvs_q, dvs_d;     // divisor
   logic [din1_WIDTH:0]   pr_q, pr_d;       // partial remainder
   logic [din0_WIDTH-1:0] q_q, q_d;         // quotient magnitude, shifted in LSB first
   logic                  neg_q, neg_d;     // dividend sign
   logic                  dbz_q, dbz_d;     // divide-by-zero pending for FIN

   // Output registers.
   logic                  done_q, done_d;
   logic [dout_WIDTH-1:0] quot_q, quot_d;
   logic [dout_WIDTH-1:0] rem_q, rem_d;
   logic                  div_by_zero_q, div_by_zero_d;
   logic                  ovf_q, ovf_d;

   // Combinational helpers.
   logic [din0_WIDTH-1:0] din0_mag;
   logic [din1_WIDTH:0]   step_pr;
   logic                  step_qbit;
   logic [dout_WIDTH-1:0] q_low;
   logic [dout_WIDTH-1:0] r_ext;
   logic [dout_WIDTH-1:0] dvd_low;
   logic                  q_big;
   logic                  q_ovf;
   logic [31:0]           unused_id;

   // Instance tag only; it has no functional effect.
   assign unused_id = ID;

   // Magnitude fits din0_WIDTH unsigned bits even for the most negative
   // input, so sign + magnitude together cover din0_WIDTH+1 bits.
   assign din0_mag = din0[din0_WIDTH-1] ? $unsigned(-din0) : $unsigned(din0);

   adpcm_div_step #(
      .din1_WIDTH(din1_WIDTH)
   ) u_step (
      .pr_i     (pr_q),
      .bit_i    (dvd_q[din0_WIDTH-1]),
      .divisor_i(dvs_q),
      .pr_o     (step_pr),
      .qbit_o   (step_qbit)
   );

   // Result shaping: wrap to output width, detect magnitude overflow.
   // A negative result may reach 2^(dout_WIDTH-1); a positive one may not.
   assign q_low   = q_q[dout_WIDTH-1:0];
   assign r_ext   = dout_WIDTH'(pr_q);
   assign dvd_low = dout_WIDTH'(dvd_q);
   assign q_big   = |q_q[din0_WIDTH-1:dout_WIDTH];
   assign q_ovf   = neg_q ? (q_big | (q_q[dout_WIDTH-1] & (|q_q[dout_WIDTH-2:0])))
                          : (q_big | q_q[dout_WIDTH-1]);

   // Next-state and next-output logic for the IDLE/CALC/FIN sequence.
   always_comb begin
      // NOTE: every signal gets a hold/default value first, so no path through
      // the case below can leave one unassigned and infer a latch.
      state_d       = state_q;
      cnt_d         = cnt_q;
      dvd_d         = dvd_q;
      dvs_d         = dvs_q;
      pr_d          = pr_q;
      q_d           = q_q;
      neg_d         = neg_q;
      dbz_d         = dbz_q;
      done_d        = 1'b0;
      quot_d        = quot_q;
      rem_d         = rem_q;
      div_by_zero_d = div_by_zero_q;
      ovf_d         = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               neg_d = din0[din0_WIDTH-1];
               dvd_d = din0_mag;
               dvs_d = din1;
               pr_d  = '0;
               q_d   = '0;
               cnt_d = CNT_INIT;
               if (din1 == '0) begin
                  dbz_d   = 1'b1;
                  state_d = S_FIN;
               end else begin
                  dbz_d   = 1'b0;
                  state_d = S_CALC;
               end
            end
         end

         S_CALC: begin
            pr_d  = step_pr;
            q_d   = {q_q[din0_WIDTH-2:0], step_qbit};
            dvd_d = {dvd_q[din0_WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = S_FIN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         S_FIN: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (dbz_q) begin
               quot_d        = '0;
               rem_d         = neg_q ? -dvd_low : dvd_low;
               div_by_zero_d = 1'b1;
               ovf_d         = 1'b0;
            end else begin
               quot_d        = neg_q ? -q_low : q_low;
               rem_d         = neg_q ? -r_ext : r_ext;
               div_by_zero_d = 1'b0;
               ovf_d         = q_ovf;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State update: synchronous reset wins over ce; ce=0 freezes everything.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (!reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         dvd_q         <= '0;
         dvs_q         <= '0;
         pr_q          <= '0;
         q_q           <= '0;
         neg_q         <= 1'b0;
         dbz_q         <= 1'b0;
         done_q        <= 1'b0;
         quot_q        <= '0;
         rem_q         <= '0;
         div_by_zero_q <= 1'b0;
         ovf_q         <= 1'b0;
      end else if (ce) begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         dvd_q         <= dvd_d;
         dvs_q         <= dvs_d;
         pr_q          <= pr_d;
         q_q           <= q_d;
         neg_q         <= neg_d;
         dbz_q         <= dbz_d;
         done_q        <= done_d;
         quot_q        <= quot_d;
         rem_q         <= rem_d;
         div_by_zero_q <= div_by_zero_d;
         ovf_q         <= ovf_d;
      end
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign quot        = quot_q;
   assign rem         = rem_q;
   assign div_by_zero = div_by_zero_q;
   assign ovf         = ovf_q;

endmodule

// File: tb/tb_adpcm_main_sdiv_45s_13ns_32_seq.sv
// Randomized scoreboard bench for the sequential divider. Expected results
// come from C-style longint division; a monitor pops them on each done pulse.
module tb_adpcm_main_sdiv_45s_13ns_32_seq;

   logic               clk;
   logic               reset;
   logic               ce;
   logic               start;
   logic signed [44:0] din0;
   logic [12:0]        din1;
   logic               busy;
   logic               done;
   logic [31:0]        quot;
   logic [31:0]        rem;
   logic               div_by_zero;
   logic               ovf;

   typedef struct {
      logic [31:0] quot;
      logic [31:0] rem;
      logic        ovf;
      logic        dbz;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   done_prev;

   adpcm_main_sdiv_45s_13ns_32_seq #(
      .ID(1), .din0_WIDTH(45), .din1_WIDTH(13), .dout_WIDTH(32)
   ) dut (
      .clk(clk), .reset(reset), .ce(ce), .start(start),
      .din0(din0), .din1(din1),
      .busy(busy), .done(done), .quot(quot), .rem(rem),
      .div_by_zero(div_by_zero), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference: truncating division on 64-bit signed integers.
   function automatic exp_t model(input logic signed [44:0] a, input logic [12:0] b);
      exp_t   e;
      longint sa, sb, q, r;
      sa = a;
      sb = b;
      if (b == 13'd0) begin
         e.quot = 32'd0;
         e.rem  = sa[31:0];
         e.ovf  = 1'b0;
         e.dbz  = 1'b1;
      end else begin
         q      = sa / sb;
         r      = sa % sb;
         e.quot = q[31:0];
         e.rem  = r[31:0];
         e.ovf  = (q > longint'(2147483647)) || (q < (-longint'(2147483647) - 1));
         e.dbz  = 1'b0;
      end
      return e;
   endfunction

   // Monitor: one scoreboard pop per rising edge of done.
   always @(negedge clk) begin
      if (done === 1'b1 && !done_prev) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("quot", 64'(quot), 64'(mon_e.quot));
            check("rem", 64'(rem), 64'(mon_e.rem));
            check("ovf", 64'(ovf), 64'(mon_e.ovf));
            check("div_by_zero", 64'(div_by_zero), 64'(mon_e.dbz));
         end
      end
      done_prev = (done === 1'b1);
   end

   // One operation from IDLE, with optional spurious starts, a ce stall,
   // and a ce hold right after done.
   task automatic do_op(input logic signed [44:0] a, input logic [12:0] b,
                        input int stall_at, input int stall_len,
                        input bit spurious, input bit hold_done);
      int lat_en, lat_all, bcnt, exp_lat;
      exp_lat = (b == 13'd0) ? 1 : 46;
      sb_q.push_back(model(a, b));
      start = 1'b1;
      din0  = a;
      din1  = b;
      @(posedge clk);
      #1;
      start   = 1'b0;
      din0    = 45'($urandom());
      din1    = 13'($urandom());
      lat_en  = 0;
      lat_all = 0;
      bcnt    = 0;
      while (done !== 1'b1 && lat_all < 400) begin
         if (busy === 1'b1) bcnt++;
         start = spurious && (lat_all == 5 || lat_all == 20);
         ce    = !(stall_len > 0 && lat_all >= stall_at && lat_all < stall_at + stall_len);
         @(posedge clk);
         if (ce) lat_en++;
         lat_all++;
         #1;
      end
      start = 1'b0;
      ce    = 1'b1;
      check("latency_enabled", 64'(lat_en), 64'(exp_lat));
      check("latency_wall", 64'(lat_all), 64'(exp_lat + stall_len));
      check("busy_cycles", 64'(bcnt), 64'(exp_lat + stall_len));
      check("busy_at_done", 64'(busy), 64'd0);
      if (hold_done) begin
         ce = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         check("done_held_ce0", 64'(done), 64'd1);
         ce = 1'b1;
         @(posedge clk);
         #1;
         check("done_cleared_ce1", 64'(done), 64'd0);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [63:0]        r64;
      logic signed [44:0] ra;
      logic [12:0]        rb;
      int                 saw;

      reset = 1'b0;
      ce    = 1'b1;
      start = 1'b0;
      din0  = '0;
      din1  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_quot", 64'(quot), 64'd0);
      check("rst_rem", 64'(rem), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Directed cases, issued back to back.
      do_op(45'sd12345, 13'd100, 0, 0, 1'b0, 1'b0);
      do_op(-45'sd1000, 13'd7, 0, 0, 1'b0, 1'b0);
      do_op(45'sd1000, 13'd7, 0, 0, 1'b0, 1'b0);
      do_op(-45'sd5, 13'd0, 0, 0, 1'b0, 1'b1);
      do_op(45'sd9, 13'd3, 0, 0, 1'b0, 1'b0);
      do_op(45'sd2147483647, 13'd1, 0, 0, 1'b0, 1'b0);
      do_op(45'sd12345, 13'd100, 0, 0, 1'b1, 1'b0);
      do_op(-45'sd1000, 13'd7, 15, 10, 1'b0, 1'b1);
      do_op(45'h1000_0000_0000, 13'd8191, 0, 0, 1'b0, 1'b0);

      // Reset in the middle of CALC aborts without a done.
      start = 1'b1;
      din0  = 45'sd777777;
      din1  = 13'd333;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (21) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_quot", 64'(quot), 64'd0);
      check("abort_rem", 64'(rem), 64'd0);
      check("abort_ovf", 64'(ovf), 64'd0);
      saw = 0;
      repeat (60) begin
         @(posedge clk);
         #1;
         if (done === 1'b1) saw++;
      end
      check("abort_no_done", 64'(saw), 64'd0);
      do_op(45'sd12345, 13'd100, 0, 0, 1'b0, 1'b0);

      // Randomized operands: full-range, shrunk magnitudes and edge divisors.
      for (int i = 0; i < 25; i++) begin
         r64 = {$urandom(), $urandom()};
         ra  = $signed(r64[44:0]) >>> $urandom_range(0, 44);
         case ($urandom_range(0, 9))
            0:       rb = 13'd0;
            1:       rb = 13'd1;
            2:       rb = 13'd8191;
            default: rb = 13'($urandom());
         endcase
         do_op(ra, rb, 0, 0, 1'b0, 1'b0);
      end

      repeat (5) @(posedge clk);
      #1;
      check("pending_results", 64'(sb_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
